// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: op encodings, FSM states, counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

  // Operation select, equal to funct3[1:0] of the RV32M divide group
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  // Iteration counter width able to hold the value Width
  function automatic int unsigned div_cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic logic op_is_signed(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Final result selection: sign correction of quotient/remainder plus divide-by-zero and overflow overrides.
// Latency: combinational.
// Backpressure: none.
module div_sign_fix
  import div_pkg::*;
#(
  parameter int unsigned Width = DIV_WIDTH
) (
  input  logic             is_rem_i,
  input  logic             div0_i,
  input  logic             ovf_i,
  input  logic             neg_q_i,
  input  logic             neg_r_i,
  input  logic [Width-1:0] quo_i,
  input  logic [Width-1:0] rem_i,
  output logic [Width-1:0] res_o
);

  localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};

  logic [Width-1:0] q_fix;
  logic [Width-1:0] r_fix;

  // Magnitude result -> signed result, then special-case overrides
  always_comb begin
    q_fix = neg_q_i ? (-quo_i) : quo_i;
    r_fix = neg_r_i ? (-rem_i) : rem_i;
    res_o = is_rem_i ? r_fix : q_fix;
    if (div0_i) begin
      // With a zero divisor every trial subtract succeeds, so the remainder
      // register ends holding |dividend|; re-signing it yields rs1 unchanged.
      if (!is_rem_i) begin
        res_o = '1;
      end
    end else if (ovf_i) begin
      res_o = is_rem_i ? '0 : MinNeg;
    end
  end

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU radix-2 restoring divider with start/busy/done handshake. Optional macro: DIV_FASTPATH_EN.
// Latency: Width+2 cycles from start to done; 1 cycle for div-by-zero/overflow when DIV_FASTPATH_EN is defined.
// Backpressure: none; start is only accepted in IDLE, the pipeline stalls on busy.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned Width = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [Width-1:0] rs1Data,
  input  logic [Width-1:0] rs2Data,
  input  logic [4:0]       rdIn,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] result,
  output logic [4:0]       rdOut,
  output logic             regWrite
);

  localparam int unsigned      CntW    = div_cnt_w(Width);
  localparam logic [Width-1:0] MinNeg  = {1'b1, {(Width-1){1'b0}}};
  localparam logic [CntW-1:0]  CntInit = CntW'(Width);
  localparam logic [CntW-1:0]  CntLast = CntW'(1);

  // Request-side decode of the raw operands, only meaningful at the accepting edge
  div_op_e          op_in;
  logic             in_signed;
  logic             in_neg1;
  logic             in_neg2;
  logic             in_div0;
  logic             in_ovf;
  logic [Width-1:0] in_abs1;
  logic [Width-1:0] in_abs2;

  assign op_in     = div_op_e'(op);
  assign in_signed = op_is_signed(op_in);
  assign in_neg1   = in_signed & rs1Data[Width-1];
  assign in_neg2   = in_signed & rs2Data[Width-1];
  assign in_abs1   = in_neg1 ? (-rs1Data) : rs1Data;
  assign in_abs2   = in_neg2 ? (-rs2Data) : rs2Data;
  assign in_div0   = (rs2Data == '0);
  assign in_ovf    = in_signed && (rs1Data == MinNeg) && (rs2Data == '1);

  div_state_e       state_q;
  div_op_e          op_q;
  logic [4:0]       rd_q;
  logic [Width-1:0] quo_q;     // shifts the dividend out while quotient bits shift in
  logic [Width-1:0] rem_q;
  logic [Width-1:0] dvs_q;
  logic [CntW-1:0]  cnt_q;
  logic             negq_q;
  logic             negr_q;
  logic             div0_q;
  logic             ovf_q;
  logic [Width-1:0] result_q;
  logic [4:0]       rdout_q;
  logic             done_q;
  logic             busy_q;

  logic [Width:0]   rem_sh;
  logic [Width:0]   diff;
  logic [Width-1:0] rem_d;
  logic [Width-1:0] quo_d;
  logic [Width-1:0] fix_res;

  // One restoring step: shift in the next dividend bit, keep the difference if non-negative
  always_comb begin
    rem_sh = {rem_q, quo_q[Width-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (!diff[Width]) begin
      rem_d = diff[Width-1:0];
      quo_d = {quo_q[Width-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[Width-1:0];
      quo_d = {quo_q[Width-2:0], 1'b0};
    end
  end

  div_sign_fix #(.Width(Width)) u_sign_fix (
    .is_rem_i (op_is_rem(op_q)),
    .div0_i   (div0_q),
    .ovf_i    (ovf_q),
    .neg_q_i  (negq_q),
    .neg_r_i  (negr_q),
    .quo_i    (quo_q),
    .rem_i    (rem_q),
    .res_o    (fix_res)
  );

`ifdef DIV_FASTPATH_EN
  logic [Width-1:0] fast_res;

  // Special results straight from the raw request; only consumed when div0/ovf fires
  div_sign_fix #(.Width(Width)) u_fast_fix (
    .is_rem_i (op_is_rem(op_in)),
    .div0_i   (in_div0),
    .ovf_i    (in_ovf),
    .neg_q_i  (1'b0),
    .neg_r_i  (in_neg1),
    .quo_i    ('0),
    .rem_i    (in_abs1),
    .res_o    (fast_res)
  );
`endif

  // Control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_DIV;
      rd_q     <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      rdout_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q   <= op_in;
            rd_q   <= rdIn;
            quo_q  <= in_abs1;
            dvs_q  <= in_abs2;
            rem_q  <= '0;
            cnt_q  <= CntInit;
            negq_q <= in_neg1 ^ in_neg2;
            negr_q <= in_neg1;
            div0_q <= in_div0;
            ovf_q  <= in_ovf;
            busy_q <= 1'b1;
`ifdef DIV_FASTPATH_EN
            if (in_div0 || in_ovf) begin
              result_q <= fast_res;
              rdout_q  <= rdIn;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
`else
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntLast) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q <= fix_res;
          rdout_q  <= rd_q;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign regWrite = done_q;
  assign result   = result_q;
  assign rdOut    = rdout_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of reference results, latency and handshake checks.
// Latency: expects Width+2 cycles, or 1 cycle for special cases when DIV_FASTPATH_EN is defined.
// Backpressure: n/a.
module tb_div_unit;
  import div_pkg::*;

  localparam int W = 32;
  localparam int LAT_FULL = W + 2;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs1Data;
  logic [W-1:0] rs2Data;
  logic [4:0]   rdIn;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [4:0]   rdOut;
  logic         regWrite;

  always #5 clk = ~clk;

  div_unit #(.Width(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs1Data  (rs1Data),
    .rs2Data  (rs2Data),
    .rdIn     (rdIn),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rdOut    (rdOut),
    .regWrite (regWrite)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   rd;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [W-1:0] ref_res(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    if (b == '0) return o[1] ? a : '1;
    if (!o[0] && a == MIN_NEG && b == '1) return o[1] ? '0 : MIN_NEG;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_FASTPATH_EN
    if (b == '0) return 1;
    if (!o[0] && a == MIN_NEG && b == '1) return 1;
`endif
    return LAT_FULL + 0 * (int'(o) + int'(a[0]));
  endfunction

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] t);
    exp_t e;
    e.res = ref_res(o, a, b);
    e.rd  = t;
    e.lat = exp_lat(o, a, b);
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1; op = o; rs1Data = a; rs2Data = b; rdIn = t;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done, counting cycles after the accepting edge and busy cycles before done
  task automatic wait_done(output logic [W-1:0] r, output logic [4:0] t, output int lat,
                           output int busy_cnt, output logic rw, output bit timed_out);
    bit stop;
    stop = 0; lat = 0; busy_cnt = 0; timed_out = 0; r = '0; t = '0; rw = 1'b0;
    while (!stop) begin
      @(negedge clk);
      lat++;
      if (done) begin
        r = result; t = rdOut; rw = regWrite; stop = 1;
      end else begin
        if (busy) busy_cnt++;
        if (lat > 200) begin timed_out = 1; stop = 1; end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs1Data = '0; rs2Data = '0; rdIn = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (regWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%b want=0", regWrite); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%h want=0", result); end
    checks++; if (rdOut !== '0) begin failures++; $display("FAIL reset_rdout got=%h want=0", rdOut); end
    rst_n = 1'b1;
  endtask

  task automatic test_div_basic();
    exp_t e; logic [W-1:0] r; logic [4:0] t; int lat, bc; logic rw; bit to;
    issue(2'(OP_DIV), 32'd20, 32'd3, 5'd5);
    wait_done(r, t, lat, bc, rw, to);
    e = sb_q.pop_front();
    checks++; if (to) begin failures++; $display("FAIL basic_timeout no done within bound"); end
    checks++; if (r !== e.res) begin failures++; $display("FAIL basic_result got=%h want=%h", r, e.res); end
    checks++; if (t !== e.rd) begin failures++; $display("FAIL basic_rd got=%0d want=%0d", t, e.rd); end
    checks++; if (lat != e.lat) begin failures++; $display("FAIL basic_latency got=%0d want=%0d", lat, e.lat); end
    checks++; if (bc != e.lat - 1) begin failures++; $display("FAIL basic_busy_cycles got=%0d want=%0d", bc, e.lat - 1); end
    checks++; if (rw !== 1'b1) begin failures++; $display("FAIL basic_regwrite got=%b want=1", rw); end
    @(negedge clk);
    checks++; if ({done, regWrite, busy} !== 3'b000) begin failures++; $display("FAIL basic_after_done got=%b want=000", {done, regWrite, busy}); end
  endtask

  // Table-driven signed/unsigned, divide-by-zero and overflow cases
  task automatic test_table(input string name, input logic [1:0] ops [], input logic [W-1:0] as [], input logic [W-1:0] bs []);
    exp_t e; logic [W-1:0] r; logic [4:0] t; int lat, bc; logic rw; bit to;
    for (int i = 0; i < ops.size(); i++) begin
      issue(ops[i], as[i], bs[i], 5'(i + 1));
      wait_done(r, t, lat, bc, rw, to);
      e = sb_q.pop_front();
      checks++; if (to || r !== e.res || t !== e.rd) begin failures++;
        $display("FAIL %s_%0d result got=%h rd=%0d want=%h rd=%0d timeout=%0d", name, i, r, t, e.res, e.rd, to); end
      checks++; if (lat != e.lat) begin failures++; $display("FAIL %s_%0d latency got=%0d want=%0d", name, i, lat, e.lat); end
      @(negedge clk);
      checks++; if ({done, busy} !== 2'b00) begin failures++; $display("FAIL %s_%0d single_pulse got=%b want=00", name, i, {done, busy}); end
    end
  endtask

  task automatic test_sign_rules();
    logic [1:0]   o [] = '{2'(OP_REM), 2'(OP_REMU), 2'(OP_DIVU), 2'(OP_DIV), 2'(OP_DIV), 2'(OP_REM), 2'(OP_DIV), 2'(OP_REM)};
    logic [W-1:0] a [] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'd20, 32'hFFFF_FFEC, 32'hFFFF_FFEC};
    logic [W-1:0] b [] = '{32'd3, 32'd3, 32'd3, 32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
    test_table("sign", o, a, b);
  endtask

  task automatic test_div_zero();
    logic [1:0]   o [] = '{2'(OP_DIVU), 2'(OP_REMU), 2'(OP_DIV), 2'(OP_REM), 2'(OP_REM)};
    logic [W-1:0] a [] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, MIN_NEG};
    logic [W-1:0] b [] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    test_table("divzero", o, a, b);
  endtask

  task automatic test_overflow();
    logic [1:0]   o [] = '{2'(OP_DIV), 2'(OP_REM), 2'(OP_DIVU), 2'(OP_REMU)};
    logic [W-1:0] a [] = '{MIN_NEG, MIN_NEG, MIN_NEG, MIN_NEG};
    logic [W-1:0] b [] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    test_table("overflow", o, a, b);
  endtask

  // start pulses during CALC/FIX and operand changes are ignored; start right after done is taken
  task automatic test_back_to_back();
    exp_t e; logic [W-1:0] r; logic [4:0] t; int lat, bc; logic rw; bit to; bit stop;
    issue(2'(OP_DIV), 32'd1000, 32'd7, 5'd9);
    lat = 0; stop = 0; to = 0; r = '0; t = '0;
    while (!stop) begin
      @(negedge clk);
      lat++;
      if (done) begin
        r = result; t = rdOut; stop = 1; start = 1'b0;
      end else if (lat > 200) begin
        to = 1; stop = 1; start = 1'b0;
      end else begin
        start = (lat == 1 || lat == 10 || lat == 33);
        op = 2'(OP_DIVU); rdIn = 5'd3;
        rs1Data = $urandom; rs2Data = (lat == 10) ? '0 : $urandom;
      end
    end
    e = sb_q.pop_front();
    checks++; if (to || r !== e.res || t !== e.rd) begin failures++;
      $display("FAIL ignore_start result got=%h rd=%0d want=%h rd=%0d timeout=%0d", r, t, e.res, e.rd, to); end
    checks++; if (lat != e.lat) begin failures++; $display("FAIL ignore_start_latency got=%0d want=%0d", lat, e.lat); end
    issue(2'(OP_REMU), 32'd1000, 32'd7, 5'd12);
    wait_done(r, t, lat, bc, rw, to);
    e = sb_q.pop_front();
    checks++; if (to || r !== e.res || t !== e.rd) begin failures++;
      $display("FAIL b2b result got=%h rd=%0d want=%h rd=%0d timeout=%0d", r, t, e.res, e.rd, to); end
    checks++; if (lat != e.lat) begin failures++; $display("FAIL b2b_latency got=%0d want=%0d", lat, e.lat); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    exp_t e; logic [W-1:0] r; logic [4:0] t; int lat, bc; logic rw; bit to; int seen;
    @(negedge clk);
    start = 1'b1; op = 2'(OP_DIV); rs1Data = 32'd12345; rs2Data = 32'd6; rdIn = 5'd17;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, regWrite} !== 3'b000) begin failures++; $display("FAIL abort_flags got=%b want=000", {busy, done, regWrite}); end
    checks++; if (result !== '0 || rdOut !== '0) begin failures++; $display("FAIL abort_outputs got=%h/%0d want=0/0", result, rdOut); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL abort_no_done got=%0d want=0", seen); end
    issue(2'(OP_DIV), 32'd100, 32'd7, 5'd4);
    wait_done(r, t, lat, bc, rw, to);
    e = sb_q.pop_front();
    checks++; if (to || r !== e.res || t !== e.rd) begin failures++;
      $display("FAIL after_abort result got=%h rd=%0d want=%h rd=%0d timeout=%0d", r, t, e.res, e.rd, to); end
    @(negedge clk);
  endtask

  task automatic test_random();
    exp_t e; logic [W-1:0] r; logic [4:0] t; int lat, bc; logic rw; bit to;
    logic [1:0] o; logic [W-1:0] a, b;
    for (int i = 0; i < 16; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i % 6 == 0) b = '0;
      if (i % 7 == 3) begin a = MIN_NEG; b = '1; end
      issue(o, a, b, 5'($urandom));
      wait_done(r, t, lat, bc, rw, to);
      e = sb_q.pop_front();
      checks++; if (to || r !== e.res || t !== e.rd || lat != e.lat) begin failures++;
        $display("FAIL random_%0d op=%0d a=%h b=%h got=%h rd=%0d lat=%0d want=%h rd=%0d lat=%0d",
                 i, o, a, b, r, t, lat, e.res, e.rd, e.lat); end
    end
  endtask

  initial begin
    test_reset();
    test_div_basic();
    test_sign_rules();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
